// File: rtl/axis_crc32_mpeg2_check_if.sv
// AXI-Stream data/handshake bundle for the CRC-32/MPEG-2 checker ports.
interface axis_crc32_mpeg2_check_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_crc32_mpeg2_check.sv
// Receive-side CRC-32/MPEG-2 checker: recomputes the CRC per packet, strips the
// trailing CRC word, re-marks tlast on the last payload word and reports pass/fail.
module axis_crc32_mpeg2_check #(
  parameter int unsigned                AXI_DATA_WIDTH = 32,
  parameter logic [AXI_DATA_WIDTH-1:0]  INIT_CRC       = 32'hFFFF_FFFF,
  parameter logic [AXI_DATA_WIDTH-1:0]  POLY_CRC       = 32'h04C1_1DB7,
  parameter int unsigned                ERR_CNT_WIDTH  = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  axis_crc32_mpeg2_check_if.slave   s_axis,
  axis_crc32_mpeg2_check_if.master  m_axis,
  output logic                      crc_done,
  output logic                      crc_ok,
  output logic [ERR_CNT_WIDTH-1:0]  crc_err_count
);
  localparam int unsigned DW = AXI_DATA_WIDTH;

  // 32 MSB-first polynomial steps, unrolled into one combinational chain.
  function automatic logic [DW-1:0] crc_f(input logic [DW-1:0] x);
    logic [DW-1:0] v;
    v = x;
    for (int i = 0; i < int'(DW); i++) begin
      v = v[DW-1] ? ((v << 1) ^ POLY_CRC) : (v << 1);
    end
    return v;
  endfunction

  logic [DW-1:0]            crc_q, crc_d;
  logic                     h_vld_q, h_vld_d;
  logic [DW-1:0]            h_data_q, h_data_d;
  logic                     o_vld_q, o_vld_d;
  logic [DW-1:0]            o_data_q, o_data_d;
  logic                     o_last_q, o_last_d;
  logic                     done_q, done_d;
  logic                     ok_q, ok_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic          in_ready;
  logic          in_hs;
  logic          out_hs;
  logic [DW-1:0] crc_next;

  assign in_ready = !o_vld_q || m_axis.tready;
  assign in_hs    = s_axis.tvalid && in_ready;
  assign out_hs   = o_vld_q && m_axis.tready;
  assign crc_next = crc_f(crc_q ^ s_axis.tdata);

  always_comb begin
    crc_d     = crc_q;
    h_vld_d   = h_vld_q;
    h_data_d  = h_data_q;
    o_vld_d   = o_vld_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_cnt_d = err_cnt_q;

    if (out_hs) begin
      o_vld_d = 1'b0;
    end

    if (in_hs) begin
      // Held word is only released once we know whether it is the last payload word.
      if (h_vld_q) begin
        o_vld_d  = 1'b1;
        o_data_d = h_data_q;
        o_last_d = s_axis.tlast;
      end
      if (s_axis.tlast) begin
        crc_d   = INIT_CRC;
        h_vld_d = 1'b0;
        done_d  = 1'b1;
        ok_d    = (crc_next == '0);
        if ((crc_next != '0) && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
      end else begin
        crc_d    = crc_next;
        h_vld_d  = 1'b1;
        h_data_d = s_axis.tdata;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      crc_q     <= INIT_CRC;
      h_vld_q   <= 1'b0;
      h_data_q  <= '0;
      o_vld_q   <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      crc_q     <= crc_d;
      h_vld_q   <= h_vld_d;
      h_data_q  <= h_data_d;
      o_vld_q   <= o_vld_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = o_vld_q;
  assign m_axis.tdata  = o_data_q;
  assign m_axis.tlast  = o_last_q;
  assign crc_done      = done_q;
  assign crc_ok        = ok_q;
  assign crc_err_count = err_cnt_q;
endmodule

// File: tb/tb_axis_crc32_mpeg2_check.sv
// Bench for axis_crc32_mpeg2_check: directed plan plus random packets scored against
// a standard bitwise CRC-32/MPEG-2 model; a 2-bit-counter instance checks saturation.
module tb_axis_crc32_mpeg2_check;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b1;

  logic        crc_done, crc_ok;
  logic [15:0] crc_err_count;
  logic        crc_done2, crc_ok2;
  logic [1:0]  crc_err_count2;

  axis_crc32_mpeg2_check_if #(.DATA_W(32)) s_if ();
  axis_crc32_mpeg2_check_if #(.DATA_W(32)) m_if ();
  axis_crc32_mpeg2_check_if #(.DATA_W(32)) s2_if ();
  axis_crc32_mpeg2_check_if #(.DATA_W(32)) m2_if ();

  assign s_if.tdata   = s_tdata;
  assign s_if.tvalid  = s_tvalid;
  assign s_if.tlast   = s_tlast;
  assign m_if.tready  = m_tready;
  assign s2_if.tdata  = s_tdata;
  assign s2_if.tvalid = s_tvalid;
  assign s2_if.tlast  = s_tlast;
  assign m2_if.tready = m_tready;

  axis_crc32_mpeg2_check dut (
    .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if),
    .crc_done(crc_done), .crc_ok(crc_ok), .crc_err_count(crc_err_count)
  );

  axis_crc32_mpeg2_check #(.ERR_CNT_WIDTH(2)) dut2 (
    .aclk(aclk), .areset(areset), .s_axis(s2_if), .m_axis(m2_if),
    .crc_done(crc_done2), .crc_ok(crc_ok2), .crc_err_count(crc_err_count2)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Textbook bit-serial CRC over the payload words, MSB first.
  function automatic logic [31:0] crc_ref(input logic [31:0] w [8], input int n);
    logic [31:0] c;
    logic        fb;
    c = INIT;
    for (int i = 0; i < n; i++) begin
      for (int b = 31; b >= 0; b--) begin
        fb = c[31] ^ w[i][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  logic [32:0] exp_beats[$];
  logic [32:0] exp_beats2[$];
  bit          exp_ok[$];
  logic [31:0] pkt [8];

  // Monitor state
  bit          pend_done = 0;
  bit          pend_ok = 0;
  bit          pend_pl = 0;
  int          n_pkt_words = 0;
  int          err_model = 0;
  bit          stall_prev = 0;
  logic [32:0] prev_beat = '0;

  always @(negedge aclk) begin
    logic [32:0] e;
    if (areset) begin
      pend_done   = 0;
      stall_prev  = 0;
      n_pkt_words = 0;
      err_model   = 0;
    end else begin
      chk("s_tready", 64'(s_if.tready), 64'(!m_if.tvalid || m_tready));
      chk("s2_tready", 64'(s2_if.tready), 64'(!m2_if.tvalid || m_tready));
      chk("crc_done", 64'(crc_done), 64'(pend_done));
      chk("crc_done2", 64'(crc_done2), 64'(pend_done));
      if (pend_done) begin
        chk("crc_ok", 64'(crc_ok), 64'(pend_ok));
        chk("crc_ok2", 64'(crc_ok2), 64'(pend_ok));
        chk("err_cnt", 64'(crc_err_count), 64'(16'(err_model)));
        chk("err_cnt_sat", 64'(crc_err_count2), 64'((err_model > 3) ? 3 : err_model));
        if (pend_pl) chk("last_with_done", 64'({m_if.tvalid, m_if.tlast}), 64'(2'b11));
      end
      if (stall_prev) begin
        chk("stall_stable", 64'({m_if.tvalid, m_if.tlast, m_if.tdata}), 64'({1'b1, prev_beat}));
      end
      if (m_if.tvalid && m_tready) begin
        chk("beat_expected", 64'(exp_beats.size() > 0), 64'(1));
        if (exp_beats.size() > 0) begin
          e = exp_beats.pop_front();
          chk("beat", 64'({m_if.tlast, m_if.tdata}), 64'(e));
        end
      end
      if (m2_if.tvalid && m_tready) begin
        chk("beat2_expected", 64'(exp_beats2.size() > 0), 64'(1));
        if (exp_beats2.size() > 0) begin
          e = exp_beats2.pop_front();
          chk("beat2", 64'({m2_if.tlast, m2_if.tdata}), 64'(e));
        end
      end
      stall_prev = m_if.tvalid && !m_tready;
      prev_beat  = {m_if.tlast, m_if.tdata};
      pend_done  = 0;
      if (s_tvalid && s_if.tready) begin
        if (s_tlast) begin
          pend_done   = 1;
          pend_pl     = (n_pkt_words > 0);
          n_pkt_words = 0;
          chk("done_expected", 64'(exp_ok.size() > 0), 64'(1));
          if (exp_ok.size() > 0) begin
            pend_ok = exp_ok.pop_front();
            if (!pend_ok) err_model++;
          end
        end else begin
          n_pkt_words++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    bit hs;
    int n;
    hs = 0;
    n  = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!hs && n < 1000) begin
      @(negedge aclk);
      hs = s_if.tready;
      @(posedge aclk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!hs) chk("send_timeout", 64'(hs), 64'(1));
  endtask

  // Queue the expected beats/result from the packet rule, then drive it.
  task automatic send_pkt(input int len, input bit ok_v, input bit gaps);
    for (int i = 0; i < len - 1; i++) begin
      exp_beats.push_back({(i == len - 2), pkt[i]});
      exp_beats2.push_back({(i == len - 2), pkt[i]});
    end
    exp_ok.push_back(ok_v);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_word(pkt[i], (i == len - 1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_beats2.size() != 0 || pend_done) && n < 200) begin
      idle(1);
      n++;
    end
    idle(1);
    chk("drain", 64'(exp_beats.size() + exp_beats2.size() + exp_ok.size()), 64'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    idle(2);
    areset = 1'b0;
  endtask

  bit rand_done;

  initial begin
    do_reset();
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("rst_m_tdata", 64'(m_if.tdata), 64'(0));
    chk("rst_m_tlast", 64'(m_if.tlast), 64'(0));
    chk("rst_crc_done", 64'(crc_done), 64'(0));
    chk("rst_crc_ok", 64'(crc_ok), 64'(0));
    chk("rst_err_cnt", 64'(crc_err_count), 64'(0));
    chk("rst_s_tready", 64'(s_if.tready), 64'(1));

    // Two-word packet
    pkt[0] = 32'hFFFF_FFFF; pkt[1] = 32'h0000_0000;
    send_pkt(2, 1, 0);
    wait_drain();

    // Back-to-back: pass then fail
    pkt[0] = 32'hFFFF_FFFF; pkt[1] = 32'h0; pkt[2] = 32'h0;
    send_pkt(3, 1, 0);
    pkt[0] = 32'hFFFF_FFFF; pkt[1] = 32'h0000_0001;
    send_pkt(2, 0, 0);
    wait_drain();
    chk("b2b_err_cnt", 64'(crc_err_count), 64'(1));

    // Single-word packets
    pkt[0] = 32'hFFFF_FFFF;
    send_pkt(1, 1, 0);
    pkt[0] = 32'h0000_0000;
    send_pkt(1, 0, 0);
    wait_drain();
    chk("single_err_cnt", 64'(crc_err_count), 64'(2));

    // Backpressure mid-packet
    pkt[0] = 32'hFFFF_FFFF; pkt[1] = 32'h0; pkt[2] = 32'h0;
    fork
      send_pkt(3, 1, 0);
      begin
        idle(1);
        m_tready = 1'b0;
        idle(5);
        m_tready = 1'b1;
      end
    join
    wait_drain();

    // Mid-packet reset discards the partial packet
    send_word(32'hFFFF_FFFF, 1'b0);
    do_reset();
    chk("midrst_err_cnt", 64'(crc_err_count), 64'(0));
    chk("midrst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    pkt[0] = 32'hFFFF_FFFF; pkt[1] = 32'h0;
    send_pkt(2, 1, 0);
    wait_drain();

    // Saturation on the 2-bit counter instance
    pkt[0] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) send_pkt(1, 0, 0);
    wait_drain();
    chk("sat_cnt2", 64'(crc_err_count2), 64'(3));
    chk("sat_cnt16", 64'(crc_err_count), 64'(5));

    // Random packets with random gaps and downstream stalls
    rand_done = 0;
    fork
      begin
        for (int p = 0; p < 150; p++) begin
          int          len;
          bit          corrupt;
          logic [31:0] c;
          logic [31:0] flip;
          len = $urandom_range(1, 6);
          for (int i = 0; i < len - 1; i++) pkt[i] = $urandom;
          c = crc_ref(pkt, len - 1);
          corrupt = ($urandom_range(0, 2) == 0);
          flip = $urandom;
          if (flip == 32'h0) flip = 32'h1;
          pkt[len - 1] = corrupt ? (c ^ flip) : c;
          send_pkt(len, !corrupt, 1);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          m_tready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        m_tready = 1'b1;
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axis_crc32_mpeg2_check.md
# axis_crc32_mpeg2_check

Receive-side CRC-32/MPEG-2 checker for 32-bit AXI-Stream packets whose final word (tlast) carries the CRC appended by the transmit-side generator. It recomputes the CRC over every word of the packet at one word per cycle and strips the CRC word. It forwards the payload downstream with tlast moved to the last payload word, then reports pass/fail and a saturating error count. The block sits between the link/stream input and the payload consumer.

## Interface
- AXI_DATA_WIDTH, 32, stream data width; only 32 is supported.
- INIT_CRC, 32'hFFFF_FFFF, CRC register value at the start of each packet.
- POLY_CRC, 32'h04C1_1DB7, generator polynomial: MSB-first, no reflection, no final XOR.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  32  input word.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tlast  in  1  marks the CRC word (final word of packet).
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  32  payload word.
- m_axis_tvalid  out  1  payload valid.
- m_axis_tlast  out  1  last payload word of packet.
- m_axis_tready  in  1  downstream accept.
- crc_done  out  1  one-cycle pulse: packet check complete.
- crc_ok  out  1  result of the most recent check; held until the next crc_done.
- crc_err_count  out  ERR_CNT_WIDTH  count of failed packets, saturating at all-ones.

## Operation
- **CRC register C.** Loaded with INIT_CRC at reset and after every tlast handshake.
  - On each input handshake: C <= F(C ^ s_axis_tdata).
  - F applies 32 MSB-first steps: if bit31 is set, x = (x<<1)^POLY_CRC; otherwise x = x<<1.
  - The step chain is fully combinational, so throughput is one word per cycle.
- **Check rule.** The packet passes iff F(C ^ crc_word) == 0. This is the zero residue of data followed by its own CRC.
- **Payload path.** Two registers:
  - Hold H (valid, data): one-word lookahead.
  - Output O (valid, data, last): drives the m_axis outputs.
- **Handshake.** s_axis_tready = !O.valid || m_axis_tready. This is combinational from registered O.valid and the input m_axis_tready.
- **Accepted word with tlast=0:**
  - If H is valid, H moves to O with last=0.
  - The new word is loaded into H.
- **Accepted word with tlast=1:**
  - The word itself is dropped (CRC word).
  - If H is valid, H moves to O with last=1, and H is cleared.
  - If H is empty (single-word packet), nothing is output.
- **O behaviour.** O clears on an m_axis handshake unless it is reloaded in the same cycle. Simultaneous drain and load is allowed.
- **Status.** Registered, asserted the cycle after the tlast handshake:
  - crc_done = 1 for exactly one cycle.
  - crc_ok = pass.
  - On fail, crc_err_count increments unless it is all-ones.
  - Status is never back-pressured.
- **Single-word packet.** Passes iff the word == INIT_CRC.
- **Back-to-back packets.** Supported with no idle cycle. C reloads INIT_CRC in the same edge that consumes the tlast word.
- **Reset (any time, including mid-packet):**
  - C = INIT_CRC; H and O cleared.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - crc_done = 0, crc_ok = 0, crc_err_count = 0.
  - The partial packet is discarded and no crc_done is produced.

## Timing
- s_axis_tready = 1 in the first cycle after reset release.
- Payload word N appears on m_axis in the cycle after word N+1 is accepted (one-word lookahead). The latency is therefore not fixed; it depends on input pacing.
- crc_done: exactly one cycle after the tlast input handshake, regardless of m_axis_tready.
- The last payload beat (m_axis_tlast=1) becomes valid in the same cycle as crc_done.
- With m_axis_tready = 1 held: sustained 1 word/cycle in and out.
- With m_axis_tready = 0 and O full: s_axis_tready = 0; H and O are held stable; no loss or duplication.
- m_axis_tdata/tlast are stable while m_axis_tvalid = 1 and m_axis_tready = 0.

## Test plan
- **Reset.** Hold areset = 1 for 2 cycles, then release → all outputs 0, crc_err_count = 0, s_axis_tready = 1.
- **Two-word packet.** {32'hFFFFFFFF, 32'h00000000 last} with m_axis_tready = 1 → one m_axis beat FFFFFFFF with tlast = 1; crc_done pulses one cycle after the last handshake; crc_ok = 1.
- **Back-to-back, pass then fail.**
  - Packet 1: {FFFFFFFF, 00000000, 00000000 last} → beats FFFFFFFF/tlast0 and 00000000/tlast1; crc_ok = 1.
  - Packet 2, immediately after: {FFFFFFFF, 00000001 last} → beat FFFFFFFF/tlast1; crc_ok = 0; crc_err_count = 1.
- **Single-word packets.** {FFFFFFFF last} → no m_axis beat, crc_ok = 1; then {00000000 last} → crc_ok = 0, crc_err_count increments.
- **Backpressure.** Repeat the 3-word packet with m_axis_tready = 0 for 5 cycles mid-packet → s_axis_tready drops within the same cycle O is full; output beat sequence unchanged; crc_ok = 1.
- **Mid-packet reset and saturation.**
  - Assert areset after one accepted word → no crc_done; the next {FFFFFFFF, 00000000 last} passes.
  - With ERR_CNT_WIDTH = 2, send 5 failing packets → crc_err_count = 3.
